// File: rtl/am_bip_err_scheduler.sv
// Round-robin shared BIP error counter for all PCS lanes, with management read/clear.
// Optional AM_BIP_SCHED_TOTAL_EN adds a saturating all-lane error total output.
module am_bip_err_scheduler #(
   parameter int NB_LANES   = 20,
   parameter int NB_BIP     = 8,
   parameter int NB_COUNTER = 16,
   parameter int NB_LANE_ID = $clog2(NB_LANES)
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [NB_LANES-1:0]          i_am_req,
   input  logic [NB_LANES*NB_BIP-1:0]   i_recived_bip,
   input  logic [NB_LANES*NB_BIP-1:0]   i_calculated_bip,
   output logic [NB_LANES-1:0]          o_am_grant,
   input  logic                         i_rd_req,
   input  logic [NB_LANE_ID-1:0]        i_rd_lane,
   input  logic                         i_rd_clear,
   output logic                         o_rd_valid,
   output logic [NB_COUNTER-1:0]        o_rd_count,
   output logic                         o_rd_sat,
   output logic                         o_rd_err
`ifdef AM_BIP_SCHED_TOTAL_EN
   ,
   output logic [NB_COUNTER+NB_LANE_ID-1:0] o_total_errors
`endif
);

   localparam int NB_POP = $clog2(NB_BIP+1);
   localparam int NB_SUM = NB_COUNTER+1;
   localparam int IDW    = NB_LANE_ID+1;
   localparam logic [IDW-1:0] NL_W = IDW'(NB_LANES);

   function automatic logic [NB_POP-1:0] popcnt(input logic [NB_BIP-1:0] v);
      popcnt = '0;
      for (int b = 0; b < NB_BIP; b++) begin
         popcnt = popcnt + NB_POP'(v[b]);
      end
   endfunction

   logic [NB_LANE_ID-1:0] ptr_q, ptr_d;
   logic [NB_LANES-1:0]   grant_q, grant_d;
   logic                  s1_vld_q, s1_vld_d;
   logic [NB_LANE_ID-1:0] s1_lane_q, s1_lane_d;
   logic [NB_BIP-1:0]     s1_xor_q, s1_xor_d;
   logic [NB_COUNTER-1:0] cnt_q [NB_LANES];
   logic [NB_COUNTER-1:0] cnt_d [NB_LANES];
   logic [NB_LANES-1:0]   sat_q, sat_d;
   logic                  rd_valid_q;
   logic [NB_COUNTER-1:0] rd_count_q;
   logic                  rd_sat_q;
   logic                  rd_err_q;

   logic [NB_LANES-1:0]   req_m;
   logic                  win_vld;
   logic [NB_LANE_ID-1:0] win_idx;
   logic [IDW-1:0]        idx;
   logic                  rd_ok;
   logic [NB_POP-1:0]     inc;

   // Scan downward so the nearest lane after the pointer is the last to win.
   always_comb begin
      req_m   = i_am_req & ~grant_q;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int i = NB_LANES; i >= 1; i--) begin
         idx = {1'b0, ptr_q} + IDW'(i);
         if (idx >= NL_W) idx = idx - NL_W;
         if (req_m[idx[NB_LANE_ID-1:0]]) begin
            win_vld = 1'b1;
            win_idx = idx[NB_LANE_ID-1:0];
         end
      end
   end

   always_comb begin
      grant_d = '0;
      if (win_vld) grant_d[win_idx] = 1'b1;
      ptr_d     = win_vld ? win_idx : ptr_q;
      s1_vld_d  = win_vld;
      s1_lane_d = win_idx;
      s1_xor_d  = i_recived_bip[int'(win_idx)*NB_BIP +: NB_BIP]
                ^ i_calculated_bip[int'(win_idx)*NB_BIP +: NB_BIP];
   end

   assign rd_ok = i_rd_req && (int'(i_rd_lane) < NB_LANES);
   assign inc   = popcnt(s1_xor_q);

   // A clear and an update in the same cycle: the increment lands on zero.
   always_comb begin
      logic                  clr;
      logic [NB_COUNTER-1:0] base;
      logic                  base_sat;
      logic [NB_SUM-1:0]     sum;
      clr      = 1'b0;
      base     = '0;
      base_sat = 1'b0;
      sum      = '0;
      sat_d    = sat_q;
      for (int k = 0; k < NB_LANES; k++) begin
         clr      = rd_ok && i_rd_clear && (int'(i_rd_lane) == k);
         base     = clr ? '0 : cnt_q[k];
         base_sat = clr ? 1'b0 : sat_q[k];
         cnt_d[k] = base;
         sat_d[k] = base_sat;
         if (s1_vld_q && (int'(s1_lane_q) == k)) begin
            sum = {1'b0, base} + NB_SUM'(inc);
            if (sum[NB_COUNTER]) begin
               cnt_d[k] = '1;
               sat_d[k] = 1'b1;
            end else begin
               cnt_d[k] = sum[NB_COUNTER-1:0];
            end
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         ptr_q      <= NB_LANE_ID'(NB_LANES-1);
         grant_q    <= '0;
         s1_vld_q   <= 1'b0;
         s1_lane_q  <= '0;
         s1_xor_q   <= '0;
         sat_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_count_q <= '0;
         rd_sat_q   <= 1'b0;
         rd_err_q   <= 1'b0;
         for (int k = 0; k < NB_LANES; k++) cnt_q[k] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         s1_vld_q   <= s1_vld_d;
         s1_lane_q  <= s1_lane_d;
         s1_xor_q   <= s1_xor_d;
         sat_q      <= sat_d;
         rd_valid_q <= i_rd_req;
         for (int k = 0; k < NB_LANES; k++) cnt_q[k] <= cnt_d[k];
         if (i_rd_req) begin
            if (rd_ok) begin
               rd_count_q <= cnt_q[i_rd_lane];
               rd_sat_q   <= sat_q[i_rd_lane];
               rd_err_q   <= 1'b0;
            end else begin
               rd_count_q <= '0;
               rd_sat_q   <= 1'b0;
               rd_err_q   <= 1'b1;
            end
         end
      end
   end

   assign o_am_grant = grant_q;
   assign o_rd_valid = rd_valid_q;
   assign o_rd_count = rd_count_q;
   assign o_rd_sat   = rd_sat_q;
   assign o_rd_err   = rd_err_q;

`ifdef AM_BIP_SCHED_TOTAL_EN
   localparam int NB_TOT  = NB_COUNTER+NB_LANE_ID;
   localparam int NB_TOT1 = NB_TOT+1;

   logic [NB_TOT-1:0] tot_q, tot_d;
   logic [NB_TOT:0]   tot_sum;

   always_comb begin
      tot_sum = {1'b0, tot_q} + NB_TOT1'(inc);
      tot_d   = tot_q;
      if (s1_vld_q) tot_d = tot_sum[NB_TOT] ? '1 : tot_sum[NB_TOT-1:0];
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) tot_q <= '0;
      else         tot_q <= tot_d;
   end

   assign o_total_errors = tot_q;
`endif

endmodule

// File: tb/tb_am_bip_err_scheduler.sv
// Self-checking bench for am_bip_err_scheduler against a cycle-level behavioural model.
// Define AM_BIP_SCHED_TOTAL_EN to also check the all-lane total.
module tb_am_bip_err_scheduler;

   localparam int NL  = 20;
   localparam int NB  = 8;
   localparam int NC  = 16;
   localparam int NID = 5;
   localparam int CMAX = 65535;
   localparam longint TMAX = (longint'(1) << (NC+NID)) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NL-1:0]     req = '0;
   logic [NL*NB-1:0]  rcv = '0;
   logic [NL*NB-1:0]  calc = '0;
   logic [NL-1:0]     grant;
   logic              rd_req = 1'b0;
   logic [NID-1:0]    rd_lane = '0;
   logic              rd_clear = 1'b0;
   logic              rd_valid;
   logic [NC-1:0]     rd_count;
   logic              rd_sat;
   logic              rd_err;
`ifdef AM_BIP_SCHED_TOTAL_EN
   logic [NC+NID-1:0] total;
`endif

   am_bip_err_scheduler #(
      .NB_LANES(NL), .NB_BIP(NB), .NB_COUNTER(NC), .NB_LANE_ID(NID)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .i_am_req(req),
      .i_recived_bip(rcv),
      .i_calculated_bip(calc),
      .o_am_grant(grant),
      .i_rd_req(rd_req),
      .i_rd_lane(rd_lane),
      .i_rd_clear(rd_clear),
      .o_rd_valid(rd_valid),
      .o_rd_count(rd_count),
      .o_rd_sat(rd_sat),
      .o_rd_err(rd_err)
`ifdef AM_BIP_SCHED_TOTAL_EN
      ,
      .o_total_errors(total)
`endif
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     failures = 0;

   int     m_cnt [NL];
   bit     m_sat [NL];
   int     m_ptr;
   bit [NL-1:0] m_grant;
   bit     m_pv;
   int     m_pl;
   int     m_pinc;
   bit     m_rv;
   int     m_rc;
   bit     m_rs;
   bit     m_re;
   longint m_tot;

   function automatic void model_reset();
      for (int k = 0; k < NL; k++) begin
         m_cnt[k] = 0;
         m_sat[k] = 0;
      end
      m_ptr = NL-1;
      m_grant = '0;
      m_pv = 0;
      m_pl = 0;
      m_pinc = 0;
      m_rv = 0;
      m_rc = 0;
      m_rs = 0;
      m_re = 0;
      m_tot = 0;
   endfunction

   // One clock: predict, advance, compare, then apply the lane handshake.
   task automatic cycle();
      bit [NL-1:0] avail;
      bit [NL-1:0] old_grant;
      int win;
      int l;
      int s;
      old_grant = m_grant;
      if (rst) begin
         model_reset();
      end else begin
         avail = req & ~m_grant;
         win = -1;
         for (int i = 1; i <= NL; i++) begin
            int j;
            j = (m_ptr + i) % NL;
            if (win < 0 && avail[j]) win = j;
         end
         m_rv = rd_req;
         if (rd_req) begin
            l = int'(rd_lane);
            if (l >= NL) begin
               m_rc = 0; m_rs = 0; m_re = 1;
            end else begin
               m_rc = m_cnt[l]; m_rs = m_sat[l]; m_re = 0;
               if (rd_clear) begin
                  m_cnt[l] = 0; m_sat[l] = 0;
               end
            end
         end
         if (m_pv) begin
            s = m_cnt[m_pl] + m_pinc;
            if (s > CMAX) begin
               m_cnt[m_pl] = CMAX; m_sat[m_pl] = 1;
            end else begin
               m_cnt[m_pl] = s;
            end
            m_tot = m_tot + m_pinc;
            if (m_tot > TMAX) m_tot = TMAX;
         end
         m_pv = (win >= 0);
         m_grant = '0;
         if (win >= 0) begin
            m_pl = win;
            m_pinc = $countones(rcv[win*NB +: NB] ^ calc[win*NB +: NB]);
            m_grant[win] = 1'b1;
            m_ptr = win;
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (grant !== m_grant) begin
         failures++;
         $display("FAIL grant: got %h expected %h at %0t", grant, m_grant, $time);
      end
      checks++;
      if (rd_valid !== m_rv) begin
         failures++;
         $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, m_rv, $time);
      end
      checks++;
      if (rd_count !== NC'(m_rc) || rd_sat !== m_rs || rd_err !== m_re) begin
         failures++;
         $display("FAIL rd_data: got cnt=%0d sat=%b err=%b expected cnt=%0d sat=%b err=%b at %0t",
                  rd_count, rd_sat, rd_err, m_rc, m_rs, m_re, $time);
      end
`ifdef AM_BIP_SCHED_TOTAL_EN
      checks++;
      if (total !== (NC+NID)'(m_tot)) begin
         failures++;
         $display("FAIL total: got %0d expected %0d at %0t", total, m_tot, $time);
      end
`endif
      req = req & ~old_grant;
      rd_req = 1'b0;
      rd_clear = 1'b0;
   endtask

   task automatic raise(input int k, input logic [NB-1:0] r, input logic [NB-1:0] c);
      req[k] = 1'b1;
      rcv[k*NB +: NB] = r;
      calc[k*NB +: NB] = c;
   endtask

   task automatic op(input int k, input logic [NB-1:0] r, input logic [NB-1:0] c);
      raise(k, r, c);
      cycle();
      cycle();
   endtask

   task automatic read(input int k, input bit clr);
      rd_req = 1'b1;
      rd_lane = NID'(k);
      rd_clear = clr;
      cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic check_rd(input string name, input int cnt, input bit sat, input bit err);
      checks++;
      if (rd_valid !== 1'b1 || rd_count !== NC'(cnt) || rd_sat !== sat || rd_err !== err) begin
         failures++;
         $display("FAIL %s: got v=%b cnt=%0d sat=%b err=%b required cnt=%0d sat=%b err=%b",
                  name, rd_valid, rd_count, rd_sat, rd_err, cnt, sat, err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      checks++;
      if (grant !== '0 || rd_valid !== 1'b0 || rd_count !== '0 || rd_sat !== 1'b0 || rd_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got g=%h v=%b c=%0d s=%b e=%b required all zero",
                  grant, rd_valid, rd_count, rd_sat, rd_err);
      end
      rst = 1'b0;
      for (int k = 0; k < NL; k++) read(k, 1'b0);
   endtask

   task automatic test_single();
      do_reset();
      raise(3, 8'hFF, 8'h0F);
      cycle();
      checks++;
      if (grant !== 20'h00008) begin
         failures++;
         $display("FAIL single_grant: got %h required %h", grant, 20'h00008);
      end
      cycle();
      read(3, 1'b0);
      check_rd("single_read", 4, 1'b0, 1'b0);
   endtask

   task automatic test_all_lanes();
      logic [NL-1:0] one;
      logic [NB-1:0] r;
      one = 1;
      do_reset();
      for (int k = 0; k < NL; k++) begin
         r = NB'($urandom);
         raise(k, r, r ^ (NB'(1) << $urandom_range(0, NB-1)));
      end
      for (int i = 0; i < NL; i++) begin
         cycle();
         checks++;
         if (grant !== (one << i)) begin
            failures++;
            $display("FAIL drain_grant: step %0d got %h required %h", i, grant, one << i);
         end
      end
      cycle();
      cycle();
      for (int k = 0; k < NL; k++) begin
         read(k, 1'b0);
         check_rd("drain_count", 1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int n = 0; n < 8191; n++) op(7, 8'hFF, 8'h00);
      read(7, 1'b0);
      check_rd("sat_below", 65528, 1'b0, 1'b0);
      op(7, 8'hFF, 8'h00);
      read(7, 1'b0);
      check_rd("sat_hit", 65535, 1'b1, 1'b0);
      op(7, 8'h0F, 8'hF0);
      read(7, 1'b0);
      check_rd("sat_hold", 65535, 1'b1, 1'b0);
      read(7, 1'b1);
      check_rd("sat_clear", 65535, 1'b1, 1'b0);
      read(7, 1'b0);
      check_rd("sat_after_clear", 0, 1'b0, 1'b0);
   endtask

   task automatic test_clear_collision();
      do_reset();
      op(5, 8'hFF, 8'h00);
      op(5, 8'h03, 8'h00);
      read(5, 1'b0);
      check_rd("coll_pre", 10, 1'b0, 1'b0);
      raise(5, 8'h07, 8'h00);
      cycle();
      read(5, 1'b1);
      check_rd("coll_clear", 10, 1'b0, 1'b0);
      read(5, 1'b0);
      check_rd("coll_after", 3, 1'b0, 1'b0);
   endtask

   task automatic test_bad_lane();
      for (int n = 0; n < 6; n++) op(int'($urandom_range(0, NL-1)), NB'($urandom), NB'($urandom));
      read(25, 1'b1);
      check_rd("bad_lane25", 0, 1'b0, 1'b1);
      for (int n = 0; n < 4; n++) read(int'($urandom_range(NL, 31)), 1'b1);
      for (int k = 0; k < NL; k++) read(k, 1'b0);
   endtask

   task automatic test_reset_midflight();
      do_reset();
      raise(2, 8'hFF, 8'h00);
      cycle();
      checks++;
      if (grant !== 20'h00004) begin
         failures++;
         $display("FAIL mid_grant: got %h required %h", grant, 20'h00004);
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      read(2, 1'b0);
      check_rd("mid_lane2", 0, 1'b0, 1'b0);
      raise(0, 8'h01, 8'h00);
      raise(3, 8'h03, 8'h00);
      cycle();
      checks++;
      if (grant !== 20'h00001) begin
         failures++;
         $display("FAIL mid_restart: got %h required %h", grant, 20'h00001);
      end
      for (int n = 0; n < 4; n++) cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < NL; k++) begin
            if (!req[k] && $urandom_range(0, 99) < 25) raise(k, NB'($urandom), NB'($urandom));
         end
         if ($urandom_range(0, 99) < 40) begin
            rd_req = 1'b1;
            rd_lane = ($urandom_range(0, 9) == 0) ? NID'($urandom_range(NL, 31))
                                                  : NID'($urandom_range(0, NL-1));
            rd_clear = ($urandom_range(0, 99) < 30);
         end
         cycle();
      end
      for (int n = 0; n < NL+2; n++) cycle();
      for (int k = 0; k < NL; k++) read(k, 1'b0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_all_lanes();
      test_saturation();
      test_clear_collision();
      test_bad_lane();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/am_bip_err_scheduler.md
# am_bip_err_scheduler

Shares one BIP error-counting datapath among all PCS lanes. Each lane requests service when an alignment marker arrives with its received and calculated BIP. The block grants lanes round-robin, accumulates saturating per-lane error counts, and serves management read and read-clear accesses. It sits between the per-lane AM lock/BIP calculators and the management register block.

## Interface
- NB_LANES, 20, number of PCS lanes (requesters)
- NB_BIP, 8, BIP width per lane
- NB_COUNTER, 16, per-lane error counter width
- NB_LANE_ID, $clog2(NB_LANES), lane index width
- i_clock  in  1  clock
- i_reset  in  1  reset; i_reset, synchronous, active-high; clock i_clock
- i_am_req  in  NB_LANES  per-lane service request, level
- i_recived_bip  in  NB_LANES*NB_BIP  received BIPs; lane k at [k*NB_BIP +: NB_BIP]
- i_calculated_bip  in  NB_LANES*NB_BIP  calculated BIPs, same packing
- o_am_grant  out  NB_LANES  one-hot grant pulse
- i_rd_req  in  1  management access strobe
- i_rd_lane  in  NB_LANE_ID  lane addressed
- i_rd_clear  in  1  clear lane counter and sat flag on access
- o_rd_valid  out  1  response strobe
- o_rd_count  out  NB_COUNTER  lane count
- o_rd_sat  out  1  lane saturation flag
- o_rd_err  out  1  addressed lane out of range

## Operation
- Request handshake:
  - Lane k holds i_am_req[k]=1 with its BIPs stable until o_am_grant[k] pulses.
  - Lane k drops the request on the cycle after the grant.
  - While o_am_grant[k]=1, req[k] is masked from arbitration.
- Arbitration:
  - Round-robin over req & ~o_am_grant.
  - Search starts at the last granted lane + 1, wrapping NB_LANES-1 → 0.
  - At most one grant per cycle.
  - Pointer resets to NB_LANES-1, so lane 0 wins first.
- Pipeline:
  - Stage 1 registers the grant, the lane index, and XOR(rcv, calc) of the winner.
  - Stage 2 adds popcount(XOR), 0..NB_BIP, to counter[lane].
- Saturation:
  - If the sum exceeds 2^NB_COUNTER-1, the counter is held at all-ones and sat[lane] is set.
  - Counters never wrap.
- Management:
  - An access is accepted every cycle i_rd_req=1; there is no backpressure.
  - Response returns the counter and sat value held at acceptance, i.e. before the same-cycle update.
  - With i_rd_clear, the counter and sat flag are cleared. A same-cycle update to that lane is applied on top of the cleared value (counter = increment, sat=0), so no error is lost.
  - i_rd_lane ≥ NB_LANES: response with o_rd_err=1, count 0, sat 0, no state change.
- Reset values:
  - All counters, sat flags, pipeline regs, o_am_grant, o_rd_* = 0.
  - Reset mid-pipeline discards in-flight updates.

## Timing
- Request seen in cycle t (lane wins) → o_am_grant high in t+1 → counter updated at end of t+1, readable from t+2.
- Throughput: one lane update per cycle; all 20 lanes drain in 20 consecutive cycles.
- Management: i_rd_req in cycle t → o_rd_valid single-cycle pulse in t+1. o_rd_* hold their last value otherwise.

## Configuration
- AM_BIP_SCHED_TOTAL_EN defined:
  - Adds output o_total_errors, width NB_COUNTER+NB_LANE_ID, saturating at all-ones.
  - It accumulates every stage-2 increment in the same cycle as the lane counter.
  - It is cleared by reset only and is unaffected by i_rd_clear.
- AM_BIP_SCHED_TOTAL_EN not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then lane 3 req with rcv 0xFF, calc 0x0F → o_am_grant=0x8 one cycle later; read lane 3 at t+2 returns count 4, sat 0.
- All 20 reqs asserted at once, each with one differing bit → grants one-hot lanes 0,1,…,19 on consecutive cycles; every lane reads count 1.
- Lane 7 with 8 errors per op, 8191 ops, then one more → count 65528, then 65535 with sat=1. A further op keeps 65535. Read-clear returns 65535/sat 1; the next read returns 0/0.
- Lane 5 at count 10; read-clear in the same cycle as a +3 update → response 10; next read returns 3.
- Read i_rd_lane=25 → o_rd_valid=1, o_rd_err=1, count 0; all counters unchanged.
- Assert i_reset one cycle after lane 2 is granted → no grant/update completes; lane 2 reads 0; arbitration restarts at lane 0.
